// File: rtl/unsigned_div_16by8_seq.sv
// Sequential radix-2 restoring divider: 2N-bit dividend / N-bit divisor -> N-bit quotient and remainder.
// Optional macro UDIV_FAST_EXC_EN lets divide-by-zero and overflow operands bypass the iterations.
module unsigned_div_16by8_seq #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] z,
  input  logic [N-1:0]   y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   x,
  output logic [N-1:0]   r,
  output logic           ovf,
  output logic           dz
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_p;
  logic [N-1:0]  r_s;
  logic [N-1:0]  r_y;
  logic [N-1:0]  r_zlo;
  logic          r_dz;
  logic          r_ovf;

  logic          w_accept;
  logic          w_dz_in;
  logic          w_ovf_in;
  logic [N:0]    w_t;
  logic          w_ge;
  logic [N-1:0]  w_diff;

  assign w_accept = in_valid && in_ready;
  assign w_dz_in  = (y == '0);
  assign w_ovf_in = !w_dz_in && (z[2*N-1:N] >= y);

  // The partial remainder stays below y in the normal case, so t < 2y and the
  // difference always fits N bits; t[N] only matters for the compare.
  assign w_t    = {r_p, r_s[N-1]};
  assign w_ge   = (w_t >= {1'b0, r_y});
  assign w_diff = w_t[N-1:0] - r_y;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: w_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
`ifdef UDIV_FAST_EXC_EN
          w_next = (w_dz_in || w_ovf_in) ? S_DONE : S_CALC;
`else
          w_next = S_CALC;
`endif
        end
      end
      S_CALC:  if (r_cnt == '0) w_next = S_DONE;
      S_DONE:  if (out_ready)   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_p   <= '0;
      r_s   <= '0;
      r_y   <= '0;
      r_zlo <= '0;
      r_dz  <= 1'b0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= CW'(N - 1);
      r_p   <= z[2*N-1:N];
      r_s   <= z[N-1:0];
      r_y   <= y;
      r_zlo <= z[N-1:0];
      r_dz  <= w_dz_in;
      r_ovf <= w_ovf_in;
    end else if (r_state == S_CALC) begin
      r_cnt <= r_cnt - 1'b1;
      r_p   <= w_ge ? w_diff : w_t[N-1:0];
      r_s   <= {r_s[N-2:0], w_ge};
    end
  end

  // Exception results override whatever the iterations produced.
  assign x   = (r_dz || r_ovf) ? '1 : r_s;
  assign r   = r_dz ? r_zlo : (r_ovf ? '0 : r_p);
  assign ovf = r_ovf;
  assign dz  = r_dz;

endmodule

// File: tb/tb_unsigned_div_16by8_seq.sv
// Self-checking bench for unsigned_div_16by8_seq: directed cases plus random operands against an arithmetic model.
module tb_unsigned_div_16by8_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] z;
  logic [7:0]  y;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  x;
  logic [7:0]  r;
  logic        ovf;
  logic        dz;

  int checks   = 0;
  int failures = 0;

  logic [7:0] e_x, e_r;
  logic       e_ovf, e_dz;
  int         e_lat;

  unsigned_div_16by8_seq dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .z        (z),
    .y        (y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .x        (x),
    .r        (r),
    .ovf      (ovf),
    .dz       (dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division plus the exception rules.
  task automatic model(input logic [15:0] tz, input logic [7:0] ty);
    int q, m;
    e_ovf = 1'b0;
    e_dz  = 1'b0;
    if (ty == 8'd0) begin
      e_dz = 1'b1; e_x = 8'hFF; e_r = tz[7:0];
    end else if (int'(tz) / int'(ty) > 255) begin
      e_ovf = 1'b1; e_x = 8'hFF; e_r = 8'h00;
    end else begin
      q = int'(tz) / int'(ty);
      m = int'(tz) % int'(ty);
      e_x = q[7:0];
      e_r = m[7:0];
    end
    e_lat = 9;
`ifdef UDIV_FAST_EXC_EN
    if (e_dz || e_ovf) e_lat = 1;
`endif
  endtask

  // Called at the negedge of the acceptance cycle; counts cycles until out_valid and checks the result.
  task automatic collect(input string tag);
    int k;
    @(negedge clk);
    in_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_lat"}, k, e_lat);
    check({tag, "_x"}, x, e_x);
    check({tag, "_r"}, r, e_r);
    check({tag, "_ovf"}, ovf, e_ovf);
    check({tag, "_dz"}, dz, e_dz);
  endtask

  task automatic do_op(input logic [15:0] tz, input logic [7:0] ty, input int hold, input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rdy"}, in_ready, 1'b1);
    model(tz, ty);
    z = tz;
    y = ty;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    collect(tag);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      z = 16'($urandom);
      y = 8'($urandom);
      #1;
      check({tag, "_hold_v"}, out_valid, 1'b1);
      check({tag, "_hold_x"}, x, e_x);
      check({tag, "_hold_r"}, r, e_r);
      check({tag, "_hold_flags"}, {ovf, dz}, {e_ovf, e_dz});
      check({tag, "_hold_nrdy"}, in_ready, 1'b0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_rel_rdy"}, in_ready, 1'b1);
    check({tag, "_rel_nv"}, out_valid, 1'b0);
  endtask

  initial begin
    logic [15:0] tz;
    logic [7:0]  ty;
    logic [7:0]  hi;
    int          cls;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; z = '0; y = '0;
    #12;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_x", x, 8'h00);
    check("rst_r", r, 8'h00);
    check("rst_flags", {ovf, dz}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_op(16'h3039, 8'h7B, 0, "basic");
    do_op(16'hFE01, 8'hFF, 0, "max");
    do_op(16'h00FF, 8'h01, 0, "div1");
    do_op(16'h1234, 8'h00, 0, "dz");
    do_op(16'h0800, 8'h08, 0, "ovf");
    do_op(16'h00FE, 8'hFF, 0, "zhi_lt_y");
    do_op(16'h0064, 8'h0A, 5, "bp");

    // in_valid and out_ready together in DONE: only the output side completes.
    model(16'h00FF, 8'h10);
    z = 16'h00FF; y = 8'h10; in_valid = 1'b1; out_ready = 1'b0;
    collect("both_a");
    model(16'h0051, 8'h09);
    z = 16'h0051; y = 8'h09; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("both_idle_rdy", in_ready, 1'b1);
    check("both_idle_nv", out_valid, 1'b0);
    collect("both_b");
    @(negedge clk);

    // Asynchronous reset in the 4th CALC cycle.
    z = 16'h1234; y = 8'h56; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_nv", out_valid, 1'b0);
    check("mid_rst_rdy", in_ready, 1'b1);
    check("mid_rst_x", x, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("mid_rst_no_pulse", out_valid, 1'b0);
    end
    do_op(16'h0007, 8'h02, 0, "after_rst");

    for (int i = 0; i < 40; i++) begin
      cls = $urandom_range(0, 9);
      if (cls == 0) begin
        ty = 8'h00;
        tz = 16'($urandom);
      end else if (cls == 1) begin
        ty = 8'($urandom_range(1, 255));
        hi = 8'($urandom_range(ty, 255));
        tz = {hi, 8'($urandom)};
      end else begin
        ty = 8'($urandom_range(1, 255));
        hi = 8'($urandom_range(0, ty - 1));
        tz = {hi, 8'($urandom)};
      end
      do_op(tz, ty, $urandom_range(0, 2), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
